// File: rtl/wash_timer_unit.sv
// Sensor and timer stage that closes the loop around the washing machine
// controller. It turns the controller's valve and motor commands into a
// modelled water level (filled/drained) and wash/rinse/spin timeouts, all
// paced by a prescaled tick that only runs while the door is locked.
module wash_timer_unit #(
    parameter int TICK_DIV    = 100,
    parameter int LEVEL_W     = 4,
    parameter int LEVEL_FULL  = 12,
    parameter int WASH_TICKS  = 8,
    parameter int RINSE_TICKS = 6,
    parameter int SPIN_TICKS  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               door_lock,
    input  logic               motor_on,
    input  logic               fill_value_on,
    input  logic               drain_value_on,
    input  logic               soap_wash,
    input  logic               water_wash,
    output logic               filled,
    output logic               drained,
    output logic               cycle_timeout,
    output logic               spin_timeout,
    output logic [LEVEL_W-1:0] level
);

    localparam int PRESC_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_A     = (WASH_TICKS > RINSE_TICKS) ? WASH_TICKS : RINSE_TICKS;
    localparam int MAX_TICKS = (MAX_A > SPIN_TICKS) ? MAX_A : SPIN_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_WASH  = 2'd1,
        PH_RINSE = 2'd2,
        PH_SPIN  = 2'd3
    } phase_t;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               filled_q, filled_d;
    logic               drained_q, drained_d;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   duration;
    logic               cycle_to_q, cycle_to_d;
    logic               spin_to_q, spin_to_d;

    // Prescaler: runs only with the door locked, pulses tick on the wrap
    // cycle, and restarts from zero whenever the door is unlocked.
    always_comb begin
        presc_d = '0;
        tick    = 1'b0;
        if (door_lock) begin
            if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Water level model: one step per tick, held when both or neither valve
    // is open, saturating at full and empty; the status flags follow the new
    // level on the same edge.
    always_comb begin
        level_d = level_q;
        if (tick) begin
            if (fill_value_on && !drain_value_on && (level_q < LEVEL_W'(LEVEL_FULL))) begin
                level_d = level_q + LEVEL_W'(1);
            end else if (!fill_value_on && drain_value_on && (level_q != '0)) begin
                level_d = level_q - LEVEL_W'(1);
            end
        end
        filled_d  = (level_d >= LEVEL_W'(LEVEL_FULL));
        drained_d = (level_d == '0);
    end

    // Phase decode from the controller outputs; spin wins over wash, wash
    // over rinse, anything else is idle.
    always_comb begin
        phase_d = PH_IDLE;
        if (motor_on && drain_value_on) begin
            phase_d = PH_SPIN;
        end else if (motor_on && soap_wash) begin
            phase_d = PH_WASH;
        end else if (motor_on && water_wash) begin
            phase_d = PH_RINSE;
        end
    end

    // Length of the phase currently being timed, in ticks.
    always_comb begin
        duration = '0;
        case (phase_q)
            PH_WASH:  duration = CNT_W'(WASH_TICKS);
            PH_RINSE: duration = CNT_W'(RINSE_TICKS);
            PH_SPIN:  duration = CNT_W'(SPIN_TICKS);
            default:  duration = '0;
        endcase
    end

    // Phase timer: a phase change restarts the count and drops both
    // timeouts (discarding any coincident tick); while the phase is stable
    // ticks accumulate up to the duration and the matching timeout is held.
    always_comb begin
        count_d    = count_q;
        cycle_to_d = cycle_to_q;
        spin_to_d  = spin_to_q;
        if ((phase_d != phase_q) || (phase_q == PH_IDLE)) begin
            count_d    = '0;
            cycle_to_d = 1'b0;
            spin_to_d  = 1'b0;
        end else begin
            if (tick && (count_q < duration)) begin
                count_d = count_q + CNT_W'(1);
            end
            cycle_to_d = (phase_q != PH_SPIN) && (count_d == duration);
            spin_to_d  = (phase_q == PH_SPIN) && (count_d == duration);
        end
    end

    // State registers with synchronous reset to the empty, idle condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            level_q    <= '0;
            filled_q   <= 1'b0;
            drained_q  <= 1'b1;
            phase_q    <= PH_IDLE;
            count_q    <= '0;
            cycle_to_q <= 1'b0;
            spin_to_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            level_q    <= level_d;
            filled_q   <= filled_d;
            drained_q  <= drained_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            cycle_to_q <= cycle_to_d;
            spin_to_q  <= spin_to_d;
        end
    end

    assign filled        = filled_q;
    assign drained       = drained_q;
    assign cycle_timeout = cycle_to_q;
    assign spin_timeout  = spin_to_q;
    assign level         = level_q;

endmodule

// File: tb/tb_wash_timer_unit.sv
// Testbench for wash_timer_unit with a fast prescaler (TICK_DIV=4).
// Each vector holds a set of controller outputs, how many clock edges to
// hold them, and the hand-derived sensor outputs expected afterwards.
module tb_wash_timer_unit;

    localparam int TICK_DIV = 4;
    localparam int LEVEL_W  = 4;

    typedef struct {
        logic rst;
        logic door;
        logic motor;
        logic fill;
        logic drain;
        logic soap;
        logic water;
        int   cycles;
        int   lvl;
        logic f;
        logic d;
        logic ct;
        logic st;
    } vec_t;

    logic               clk;
    logic               reset;
    logic               door_lock;
    logic               motor_on;
    logic               fill_value_on;
    logic               drain_value_on;
    logic               soap_wash;
    logic               water_wash;
    logic               filled;
    logic               drained;
    logic               cycle_timeout;
    logic               spin_timeout;
    logic [LEVEL_W-1:0] level;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[22];
    vec_t sb_q[$];

    wash_timer_unit #(
        .TICK_DIV    (TICK_DIV),
        .LEVEL_W     (LEVEL_W),
        .LEVEL_FULL  (12),
        .WASH_TICKS  (8),
        .RINSE_TICKS (6),
        .SPIN_TICKS  (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .door_lock      (door_lock),
        .motor_on       (motor_on),
        .fill_value_on  (fill_value_on),
        .drain_value_on (drain_value_on),
        .soap_wash      (soap_wash),
        .water_wash     (water_wash),
        .filled         (filled),
        .drained        (drained),
        .cycle_timeout  (cycle_timeout),
        .spin_timeout   (spin_timeout),
        .level          (level)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Builds one vector record from its fields.
    function automatic vec_t mk(input logic rst, input logic door, input logic motor,
                                input logic fill, input logic drain, input logic soap,
                                input logic water, input int cycles, input int lvl,
                                input logic f, input logic d, input logic ct,
                                input logic st);
        vec_t v;
        v.rst = rst; v.door = door; v.motor = motor; v.fill = fill;
        v.drain = drain; v.soap = soap; v.water = water; v.cycles = cycles;
        v.lvl = lvl; v.f = f; v.d = d; v.ct = ct; v.st = st;
        return v;
    endfunction

    // One comparison of a DUT value against the bench's expectation.
    task automatic checkField(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drives a vector onto the DUT inputs and queues its expected outputs.
    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        door_lock      = v.door;
        motor_on       = v.motor;
        fill_value_on  = v.fill;
        drain_value_on = v.drain;
        soap_wash      = v.soap;
        water_wash     = v.water;
        sb_q.push_back(v);
    endtask

    // Pops the oldest expectation and compares every output against it.
    task automatic checkOutput(input int idx);
        vec_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL row%0d scoreboard empty", idx);
        end else begin
            e = sb_q.pop_front();
            checkField($sformatf("row%0d level", idx), int'(level), e.lvl);
            checkField($sformatf("row%0d filled", idx), int'(filled), int'(e.f));
            checkField($sformatf("row%0d drained", idx), int'(drained), int'(e.d));
            checkField($sformatf("row%0d cycle_timeout", idx), int'(cycle_timeout), int'(e.ct));
            checkField($sformatf("row%0d spin_timeout", idx), int'(spin_timeout), int'(e.st));
        end
    endtask

    // Applies one table row, holds it for its edge count, then checks.
    task automatic runRow(input int idx);
        applyStimulus(vecs[idx]);
        repeat (vecs[idx].cycles) @(posedge clk);
        #1;
        checkOutput(idx);
    endtask

    // Main sequence: table rows, then the soap/water toggling sequence,
    // then the remaining rows ending in a reset during spin.
    initial begin
        //              rst door mot fill drn soap wat cyc lvl f  d  ct st
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0,  3,  0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 1, 0, 1, 0, 0, 0,  4,  1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 1, 0, 0, 0, 40, 11, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 1, 0, 0, 0,  4, 12, 1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 1, 0, 0, 0,  8, 12, 1, 0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 1, 1, 0, 0, 20, 12, 1, 0, 0, 0);
        vecs[6]  = mk(0, 1, 1, 0, 0, 1, 0, 31, 12, 1, 0, 0, 0);
        vecs[7]  = mk(0, 1, 1, 0, 0, 1, 0,  1, 12, 1, 0, 1, 0);
        vecs[8]  = mk(0, 1, 1, 0, 0, 1, 0,  8, 12, 1, 0, 1, 0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0, 1,  1, 12, 1, 0, 0, 0);
        vecs[10] = mk(0, 1, 1, 0, 0, 0, 1, 22, 12, 1, 0, 0, 0);
        vecs[11] = mk(0, 1, 1, 0, 0, 0, 1,  1, 12, 1, 0, 1, 0);
        vecs[12] = mk(0, 1, 1, 0, 1, 0, 0, 19,  8, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 0, 1, 0, 0,  1,  7, 0, 0, 0, 1);
        vecs[14] = mk(0, 1, 1, 0, 1, 0, 0, 28,  0, 0, 1, 0, 1);
        vecs[15] = mk(0, 1, 1, 0, 1, 0, 0,  8,  0, 0, 1, 0, 1);
        vecs[16] = mk(0, 0, 1, 0, 1, 0, 0, 10,  0, 0, 1, 0, 1);
        vecs[17] = mk(0, 1, 0, 0, 0, 0, 0,  4,  0, 0, 1, 0, 0);
        vecs[18] = mk(0, 1, 0, 1, 0, 0, 0, 16,  4, 0, 0, 0, 0);
        vecs[19] = mk(0, 1, 1, 1, 1, 0, 0, 20,  4, 0, 0, 0, 1);
        vecs[20] = mk(1, 1, 1, 1, 1, 0, 0,  1,  0, 0, 1, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0,  4,  0, 0, 1, 0, 0);

        for (int i = 0; i <= 17; i++) begin
            runRow(i);
        end

        // Alternate wash and rinse every three ticks; neither phase lasts
        // long enough to time out.
        for (int k = 0; k < 6; k++) begin
            reset          = 1'b0;
            door_lock      = 1'b1;
            motor_on       = 1'b1;
            fill_value_on  = 1'b0;
            drain_value_on = 1'b0;
            soap_wash      = ((k % 2) == 0);
            water_wash     = ((k % 2) != 0);
            for (int c = 0; c < 3 * TICK_DIV; c++) begin
                @(posedge clk);
                #1;
                checkField($sformatf("toggle%0d_%0d cycle_timeout", k, c), int'(cycle_timeout), 0);
                checkField($sformatf("toggle%0d_%0d spin_timeout", k, c), int'(spin_timeout), 0);
            end
        end
        checkField("toggle level", int'(level), 0);

        for (int i = 18; i <= 21; i++) begin
            runRow(i);
        end

        checkField("scoreboard drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
